// File: rtl/scr_link_pkg.sv
// scr_link_pkg: shared word type, state encoding and fixed link words
// for the scrambler link controller.
package scr_link_pkg;

    typedef logic [29:0] word_t;

    typedef enum logic [1:0] {
        HOLD,
        TRAIN,
        SYNC,
        RUN
    } state_t;

    localparam word_t TRAIN_WORD = 30'h1555_5555;
    localparam word_t SYNC_WORD  = 30'h3FFF_8000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scr_link_timer.sv
// scr_link_timer: loadable down-counter that saturates at zero;
// done is high while the count is zero.
module scr_link_timer #(
    parameter int            CW   = 8,
    parameter logic [CW-1:0] INIT = '0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= INIT;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/scr_link_ctrl.sv
// scr_link_ctrl: sequences the TX scrambler through HOLD/TRAIN/SYNC/RUN.
// Define SCR_LINK_IDLE_CNT_EN to emit a rolling counter as the RUN idle word.
module scr_link_ctrl
    import scr_link_pkg::*;
#(
    parameter int    HOLD_CYCLES = 4,
    parameter int    TRAIN_WORDS = 64,
    parameter word_t IDLE_WORD   = 30'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LINK_EN,
    input  logic        RESYNC,
    input  logic        REV_CFG,
    input  logic [29:0] DATA_IN,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    output logic [29:0] SCR_DATA,
    output logic        SCR_EN,
    output logic        SCR_REV,
    output logic        SCR_RSTN,
    output logic        LINK_UP,
    output logic [31:0] DATA_CNT
);

    localparam int CW = $clog2(max_int(HOLD_CYCLES, TRAIN_WORDS) + 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TRAIN_LD = CW'(TRAIN_WORDS - 1);

    state_t        state;
    state_t        nxt;
    logic          tmr_load;
    logic          tmr_en;
    logic          tmr_done;
    logic [CW-1:0] tmr_val;
    logic          xfer;
    word_t         idle_word;

    // Reset lands in HOLD, so the timer comes out of reset armed for it.
    scr_link_timer #(
        .CW   (CW),
        .INIT (HOLD_LD)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    assign DATA_READY = (state == RUN) && LINK_EN;
    assign xfer       = DATA_VALID && DATA_READY;

    always_comb begin
        nxt      = state;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = HOLD_LD;
        unique case (state)
            HOLD: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    nxt      = TRAIN;
                    tmr_load = 1'b1;
                    tmr_val  = TRAIN_LD;
                end
            end
            TRAIN: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    nxt = SYNC;
                end
            end
            SYNC: begin
                nxt = RUN;
            end
            RUN: begin
                if (RESYNC) begin
                    nxt      = TRAIN;
                    tmr_load = 1'b1;
                    tmr_val  = TRAIN_LD;
                end
            end
        endcase
        // Link disable wins over everything; the hold count restarts on entry.
        if (!LINK_EN) begin
            nxt      = HOLD;
            tmr_load = (state != HOLD);
            tmr_val  = HOLD_LD;
        end
    end

`ifdef SCR_LINK_IDLE_CNT_EN
    word_t idle_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idle_cnt <= '0;
        end else if (nxt == SYNC) begin
            idle_cnt <= '0;
        end else if ((nxt == RUN) && !xfer) begin
            idle_cnt <= idle_cnt + 30'd1;
        end
    end

    assign idle_word = idle_cnt;
`else
    assign idle_word = IDLE_WORD;
`endif

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= HOLD;
            SCR_RSTN <= 1'b0;
            SCR_EN   <= 1'b0;
            SCR_REV  <= 1'b0;
            SCR_DATA <= TRAIN_WORD;
            LINK_UP  <= 1'b0;
            DATA_CNT <= '0;
        end else begin
            state    <= nxt;
            SCR_RSTN <= (nxt != HOLD);
            SCR_EN   <= (nxt == RUN);
            LINK_UP  <= (nxt == RUN);
            if (state == HOLD) begin
                SCR_REV <= REV_CFG;
            end
            if (xfer) begin
                DATA_CNT <= DATA_CNT + 32'd1;
            end
            case (nxt)
                SYNC:    SCR_DATA <= SYNC_WORD;
                RUN:     SCR_DATA <= xfer ? DATA_IN : idle_word;
                default: SCR_DATA <= TRAIN_WORD;
            endcase
        end
    end

endmodule

// File: tb/tb_scr_link_ctrl.sv
// tb_scr_link_ctrl: directed bring-up/resync/hold sequence with random
// RUN traffic checked against a word-queue level model.
module tb_scr_link_ctrl;

    localparam int          H       = 4;
    localparam int          T       = 64;
    localparam logic [29:0] TRAIN_W = 30'h1555_5555;
    localparam logic [29:0] SYNC_W  = 30'h3FFF_8000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LINK_EN;
    logic        RESYNC;
    logic        REV_CFG;
    logic [29:0] DATA_IN;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [29:0] SCR_DATA;
    logic        SCR_EN;
    logic        SCR_REV;
    logic        SCR_RSTN;
    logic        LINK_UP;
    logic [31:0] DATA_CNT;

    int          total  = 0;
    int          passed = 0;
    logic [31:0] exp_cnt = '0;
    logic [29:0] idle_q  = '0;
    logic        exp_rev = 1'b0;

    scr_link_ctrl #(
        .HOLD_CYCLES (H),
        .TRAIN_WORDS (T),
        .IDLE_WORD   (30'h0000_0000)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LINK_EN    (LINK_EN),
        .RESYNC     (RESYNC),
        .REV_CFG    (REV_CFG),
        .DATA_IN    (DATA_IN),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .SCR_DATA   (SCR_DATA),
        .SCR_EN     (SCR_EN),
        .SCR_REV    (SCR_REV),
        .SCR_RSTN   (SCR_RSTN),
        .LINK_UP    (LINK_UP),
        .DATA_CNT   (DATA_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic take_idle(output logic [29:0] w);
`ifdef SCR_LINK_IDLE_CNT_EN
        w      = idle_q;
        idle_q = idle_q + 30'd1;
`else
        w = 30'h0000_0000;
`endif
    endtask

    // Training phase, sync word, then first RUN cycle.
    task automatic train_seq(input string tag);
        logic [29:0] w;
        for (int i = 0; i < T; i++) begin
            chk({tag, "_trn_rstn"}, SCR_RSTN, 1);
            chk({tag, "_trn_en"}, SCR_EN, 0);
            chk({tag, "_trn_up"}, LINK_UP, 0);
            chk({tag, "_trn_rdy"}, DATA_READY, 0);
            chk({tag, "_trn_data"}, SCR_DATA, TRAIN_W);
            chk({tag, "_trn_rev"}, SCR_REV, exp_rev);
            cyc();
        end
        chk({tag, "_sync_data"}, SCR_DATA, SYNC_W);
        chk({tag, "_sync_en"}, SCR_EN, 0);
        chk({tag, "_sync_up"}, LINK_UP, 0);
        chk({tag, "_sync_rstn"}, SCR_RSTN, 1);
        idle_q = '0;
        cyc();
        take_idle(w);
        chk({tag, "_run_up"}, LINK_UP, 1);
        chk({tag, "_run_en"}, SCR_EN, 1);
        chk({tag, "_run_data"}, SCR_DATA, w);
        chk({tag, "_run_rdy"}, DATA_READY, 1);
    endtask

    task automatic run_cycle(input logic v, input logic [29:0] d);
        logic [29:0] w;
        DATA_VALID = v;
        DATA_IN    = d;
        #1;
        chk("run_rdy", DATA_READY, 1);
        cyc();
        if (v) begin
            w       = d;
            exp_cnt = exp_cnt + 32'd1;
        end else begin
            take_idle(w);
        end
        chk("run_data", SCR_DATA, w);
        chk("run_cnt", DATA_CNT, exp_cnt);
        chk("run_up", LINK_UP, 1);
        chk("run_rev", SCR_REV, exp_rev);
        DATA_VALID = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        LINK_EN    = 1'b0;
        RESYNC     = 1'b0;
        REV_CFG    = 1'b0;
        DATA_IN    = '0;
        DATA_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_rstn", SCR_RSTN, 0);
        chk("rst_en", SCR_EN, 0);
        chk("rst_rev", SCR_REV, 0);
        chk("rst_data", SCR_DATA, TRAIN_W);
        chk("rst_rdy", DATA_READY, 0);
        chk("rst_up", LINK_UP, 0);
        chk("rst_cnt", DATA_CNT, 0);

        RST     = 1'b0;
        LINK_EN = 1'b1;
        for (int i = 0; i < H; i++) begin
            chk("hold_rstn", SCR_RSTN, 0);
            chk("hold_en", SCR_EN, 0);
            chk("hold_data", SCR_DATA, TRAIN_W);
            chk("hold_up", LINK_UP, 0);
            cyc();
        end
        train_seq("up");

        run_cycle(1'b1, 30'h0ABC_DEF1);
        run_cycle(1'b1, 30'h1234_5678);
        run_cycle(1'b0, 30'h3333_3333);
        run_cycle(1'b1, 30'h2FED_CBA9);
        chk("cnt_abc", DATA_CNT, 3);

        repeat (40) run_cycle(1'($urandom_range(0, 1)), 30'($urandom()));

        REV_CFG = 1'b1;
        repeat (3) run_cycle(1'b0, '0);

        RESYNC     = 1'b1;
        DATA_VALID = 1'b0;
        #1;
        chk("resync_rdy", DATA_READY, 1);
        cyc();
        RESYNC = 1'b0;
        train_seq("resync");
        repeat (20) run_cycle(1'($urandom_range(0, 1)), 30'($urandom()));

        LINK_EN    = 1'b0;
        RESYNC     = 1'b1;
        DATA_VALID = 1'b1;
        #1;
        chk("drop_rdy", DATA_READY, 0);
        cyc();
        RESYNC     = 1'b0;
        DATA_VALID = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("drop_rstn", SCR_RSTN, 0);
            chk("drop_en", SCR_EN, 0);
            chk("drop_up", LINK_UP, 0);
            chk("drop_data", SCR_DATA, TRAIN_W);
            chk("drop_cnt", DATA_CNT, exp_cnt);
            chk("drop_rev", SCR_REV, (i == 0) ? 0 : 1);
            cyc();
        end

        exp_rev = 1'b1;
        LINK_EN = 1'b1;
        cyc();
        train_seq("relink");
        REV_CFG = 1'b0;
        repeat (10) run_cycle(1'($urandom_range(0, 1)), 30'($urandom()));

        DATA_VALID = 1'b1;
        #3;
        RST = 1'b1;
        #1;
        chk("arst_rdy", DATA_READY, 0);
        chk("arst_up", LINK_UP, 0);
        chk("arst_cnt", DATA_CNT, 0);
        chk("arst_rstn", SCR_RSTN, 0);
        chk("arst_data", SCR_DATA, TRAIN_W);
        chk("arst_rev", SCR_REV, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/scr_link_ctrl.md
# scr_link_ctrl

Transmit-side link controller placed directly upstream of the 30-bit parallel scrambler (G = X^58 + X^39 + 1) in the ETROC1 TDC test GTX path. It sequences the scrambler through reset, an unscrambled training pattern and a sync marker, and then enables scrambling. In the run phase it forwards words from a valid/ready data source and fills empty cycles with idle words. It also latches the bit-reverse setting and reports link status.

## Interface

Parameters:
- HOLD_CYCLES, 4: number of cycles the scrambler reset (SCR_RSTN) is held low after entry to HOLD; minimum 1.
- TRAIN_WORDS, 64: number of training words sent per training phase; minimum 1.
- IDLE_WORD, 30'h0000_0000: filler word used in RUN when no data is valid.

Ports:
- CLK, input, 1: single clock, the word clock shared with the scrambler.
- RST, input, 1: reset, asynchronous and active-high.
- LINK_EN, input, 1: level signal; 1 brings the link up, 0 forces HOLD.
- RESYNC, input, 1: single-cycle pulse; in RUN it restarts training.
- REV_CFG, input, 1: requested bit-reverse setting; sampled only in HOLD.
- DATA_IN, input, 30: source data word.
- DATA_VALID, input, 1: source word valid.
- DATA_READY, output, 1: source word accepted on this edge when DATA_VALID is also 1.
- SCR_DATA, output, 30: drives the scrambler DataIn.
- SCR_EN, output, 1: drives the scrambler EN.
- SCR_REV, output, 1: drives the scrambler REV.
- SCR_RSTN, output, 1: drives the scrambler RSTn (active-low).
- LINK_UP, output, 1: 1 only in RUN.
- DATA_CNT, output, 32: count of accepted data words; wraps.

## Operation

States: HOLD, TRAIN, SYNC, RUN.

**HOLD**
- SCR_RSTN=0, SCR_EN=0, SCR_DATA=TRAIN_WORD.
- SCR_REV <= REV_CFG on every cycle in this state.
- Hold counter counts HOLD_CYCLES cycles.
- Go to TRAIN when the count is done and LINK_EN=1. Otherwise stay; the counter saturates.

**TRAIN**
- SCR_RSTN=1, SCR_EN=0, SCR_DATA=TRAIN_WORD (30'h1555_5555, alternating pattern).
- Exactly TRAIN_WORDS cycles, then SYNC.

**SYNC**
- One cycle with SCR_DATA=SYNC_WORD (30'h3FFF_8000), SCR_EN=0.
- Then RUN.

**RUN**
- SCR_EN=1, LINK_UP=1.
- DATA_READY = (state==RUN) & LINK_EN. This is a combinational decode of the registered state, with no dependency on DATA_VALID.
- On a transfer (VALID & READY): SCR_DATA <= DATA_IN and DATA_CNT increments. Otherwise SCR_DATA <= idle word.
- RESYNC=1 returns to TRAIN with the training counter cleared. SCR_RSTN stays 1 because the scrambler is self-synchronising.

**Global rules**
- LINK_EN=0 in any state: next state is HOLD with the hold counter cleared. This has priority over RESYNC.
- RESYNC outside RUN is ignored.
- SCR_REV is constant outside HOLD; REV_CFG changes there take effect only after the next HOLD.
- DATA_CNT is modulo 2^32 and is cleared only by RST.

**Reset values** (while RST=1)
- State HOLD, counters 0.
- SCR_RSTN=0, SCR_EN=0, SCR_REV=0.
- SCR_DATA=30'h1555_5555.
- DATA_READY=0, LINK_UP=0, DATA_CNT=0.
- RST asserted mid-run aborts immediately. The word in flight is lost, and DATA_READY is 0 asynchronously.

## Timing

- All outputs except DATA_READY are registered. DATA_READY is decoded from registered state and LINK_EN only.
- DATA_IN accepted at edge N appears on SCR_DATA after edge N, i.e. 1 cycle of latency. The scrambler's own input latch adds one more cycle.
- From LINK_EN rising (after the hold count is complete), cycle by cycle:
  - 1 cycle to enter TRAIN;
  - TRAIN_WORDS training words;
  - 1 sync word;
  - LINK_UP rises on the first RUN cycle, HOLD_done + TRAIN_WORDS + 2 edges after LINK_EN.
- LINK_EN falling: DATA_READY drops in the same cycle. SCR_EN, LINK_UP and SCR_RSTN change at the next edge.
- Back-to-back transfers are sustained at 1 word per clock in RUN.

## Configuration

Macro SCR_LINK_IDLE_CNT_EN:
- Defined: the idle word in RUN is a 30-bit rolling counter that increments after each idle word is emitted. It resets to 0 and also clears on entry to SYNC. The IDLE_WORD parameter is unused.
- Undefined: the idle word is the constant IDLE_WORD and no counter logic is present.

## Structure

- Package scr_link_pkg holds:
  - the state enum (HOLD, TRAIN, SYNC, RUN);
  - TRAIN_WORD = 30'h1555_5555;
  - SYNC_WORD = 30'h3FFF_8000;
  - the 30-bit word typedef.
- One sub-module, scr_link_timer: a loadable down-counter with a done flag, instanced once. It is shared by HOLD and TRAIN, since only one of those states is active at a time.
- The scrambler is not instanced inside this block; the two are connected at the level above.

## Test plan

1. **Reset and bring-up:** RST pulse, then LINK_EN=1 with HOLD_CYCLES=4 and TRAIN_WORDS=64.
   - Expect SCR_RSTN low for 4 cycles, then 64 cycles of 30'h1555_5555 with SCR_EN=0.
   - Then one cycle of 30'h3FFF_8000, then LINK_UP=1 and SCR_EN=1.
2. **Mixed traffic in RUN:** DATA_VALID pattern 1,1,0,1 carrying words A, B, C.
   - Expect SCR_DATA = A, B, idle, C, each one cycle after acceptance, and DATA_CNT=3.
3. **RESYNC in RUN:** pulse RESYNC.
   - Expect 64 training words, then the sync word, then LINK_UP=1 again.
   - SCR_RSTN stays 1 throughout; DATA_READY=0 during training.
4. **LINK_EN low mid-RUN, same cycle as RESYNC:**
   - Expect DATA_READY=0 in that cycle, then HOLD with SCR_RSTN=0, and no training.
5. **REV handling:**
   - Toggle REV_CFG during RUN: SCR_REV is unchanged.
   - Drop and raise LINK_EN: SCR_REV follows the new REV_CFG.
6. **SCR_LINK_IDLE_CNT_EN defined, no valid data for 3 RUN cycles:**
   - Expect SCR_DATA = 0, 1, 2.
   - After a RESYNC, the idle sequence restarts at 0.
